// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds the format/state enums, the canonical NOP and the base opcodes.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer for the RV32I base formats.
// Immediate range checking is compiled in only when ENC_CHECK_EN is defined.
module instr_pack
  import enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = NOP;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = NOP;
    endcase
  end

`ifdef ENC_CHECK_EN
  logic sext12, sext13, sext21;

  // An immediate fits N bits when every bit above N-1 copies bit N-1.
  assign sext12 = (imm[31:11] == {21{imm[11]}});
  assign sext13 = (imm[31:12] == {20{imm[12]}});
  assign sext21 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_R:        err = 1'b0;
      FMT_I, FMT_S: err = !sext12;
      FMT_B:        err = !sext13 || imm[0];
      FMT_U:        err = (imm[11:0] != 12'd0);
      FMT_J:        err = !sext21 || imm[0];
      default:      err = 1'b1;
    endcase
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: accepts field bundles, emits packed words with
// sequential imem addresses. Optional range check via ENC_CHECK_EN.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic              accept;
  logic [31:0]       pack_instr;
  logic              pack_err;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // cfg_load wins from any state; the accept that fills the last slot moves to FULL.
  always_comb begin
    state_nxt = state;
    if (cfg_load)
      state_nxt = ST_RUN;
    else if (state == ST_RUN && accept && (count + 1'b1) == DEPTH_C)
      state_nxt = ST_FULL;
  end

  always_comb begin
    in_ready = (state == ST_RUN) && !cfg_load && (!out_valid || out_ready);
    full     = (state == ST_FULL);
    accept   = in_valid && in_ready;
  end

  // A pending word survives cfg_load; only reset discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      err       <= 1'b0;
    end else begin
      if (cfg_load) begin
        addr  <= cfg_base;
        count <= '0;
      end else if (accept) begin
        addr  <= addr + 1'b1;
        count <= count + 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= pack_instr;
        out_addr  <= addr;
        err       <= pack_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
